// File: rtl/vga_dbuf_fb.sv
// Double-buffered VGA frame buffer: the display reads the front bank while a producer writes,
// bulk-clears the back bank, and requests swaps that commit only at a frame boundary.
module vga_dbuf_fb #(
    parameter int unsigned     H_RES    = 640,
    parameter int unsigned     V_RES    = 480,
    parameter int unsigned     SCALE    = 1,
    parameter int unsigned     PIX_W    = 24,
    parameter logic [PIX_W-1:0] BG_COLOR = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [9:0]       h_addr,
    input  logic [9:0]       v_addr,
    input  logic             frame_start,
    output logic [PIX_W-1:0] vga_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [9:0]       wr_x,
    input  logic [9:0]       wr_y,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             clear_req,
    input  logic [PIX_W-1:0] clear_color,
    input  logic             swap_req,
    output logic             busy,
    output logic             swap_done,
    output logic             front_sel
);

    localparam int unsigned FB_W  = H_RES >> SCALE;
    localparam int unsigned FB_H  = V_RES >> SCALE;
    localparam int unsigned DEPTH = FB_W * FB_H;
    localparam int unsigned MW    = $clog2(2 * DEPTH);
    localparam int unsigned CW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StClear, StSwapWait} state_e;

    state_e             state_q, state_d;
    logic               front_sel_q, front_sel_d;
    logic               swap_done_q, swap_done_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [PIX_W-1:0]   color_q, color_d;
    logic [PIX_W-1:0]   vga_data_q, vga_data_d;

    // Bank b occupies words [b*DEPTH, (b+1)*DEPTH).
    logic [PIX_W-1:0]   mem [2*DEPTH];

    logic               rd_in, wr_in, wr_fire;
    logic [MW-1:0]      rd_idx, wr_idx, clr_idx;
    int unsigned        front_base, back_base, rd_off, wr_off;

    assign wr_ready  = (state_q == StIdle) && !rst;
    assign wr_fire   = wr_valid && wr_ready;
    assign busy      = (state_q != StIdle);
    assign swap_done = swap_done_q;
    assign front_sel = front_sel_q;
    assign vga_data  = vga_data_q;

    always_comb begin
        front_base = front_sel_q ? DEPTH : 0;
        back_base  = front_sel_q ? 0 : DEPTH;
        rd_in      = (32'(h_addr) < H_RES) && (32'(v_addr) < V_RES);
        rd_off     = (32'(v_addr) >> SCALE) * FB_W + (32'(h_addr) >> SCALE);
        rd_idx     = MW'(front_base + rd_off);
        wr_in      = (32'(wr_x) < FB_W) && (32'(wr_y) < FB_H);
        wr_off     = 32'(wr_y) * FB_W + 32'(wr_x);
        wr_idx     = MW'(back_base + wr_off);
        clr_idx    = MW'(back_base + 32'(cnt_q));
        vga_data_d = rd_in ? mem[rd_idx] : BG_COLOR;
    end

    always_comb begin
        state_d     = state_q;
        front_sel_d = front_sel_q;
        swap_done_d = 1'b0;
        cnt_d       = cnt_q;
        color_d     = color_q;
        unique case (state_q)
            StIdle: begin
                // Clear has priority; a simultaneous swap request is dropped.
                if (clear_req) begin
                    state_d = StClear;
                    cnt_d   = '0;
                    color_d = clear_color;
                end else if (swap_req) begin
                    state_d = StSwapWait;
                end
            end
            StClear: begin
                if (32'(cnt_q) == DEPTH - 1) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StSwapWait: begin
                if (frame_start) begin
                    front_sel_d = ~front_sel_q;
                    swap_done_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            front_sel_q <= 1'b0;
            swap_done_q <= 1'b0;
            cnt_q       <= '0;
            color_q     <= '0;
            vga_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            front_sel_q <= front_sel_d;
            swap_done_q <= swap_done_d;
            cnt_q       <= cnt_d;
            color_q     <= color_d;
            vga_data_q  <= vga_data_d;
        end
    end

    // Memory is never reset; reset only suppresses writes so a clear in flight is aborted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == StClear) begin
                mem[clr_idx] <= color_q;
            end else if (wr_fire && wr_in) begin
                mem[wr_idx] <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_vga_dbuf_fb.sv
// Directed bench for vga_dbuf_fb with an 8x4 display scaled down to a 4x2 buffer.
module tb_vga_dbuf_fb;

    localparam int unsigned PIX_W = 24;

    logic             clk = 1'b0;
    logic             rst;
    logic [9:0]       h_addr, v_addr, wr_x, wr_y;
    logic             frame_start, wr_valid, clear_req, swap_req;
    logic [PIX_W-1:0] wr_data, clear_color, vga_data;
    logic             wr_ready, busy, swap_done, front_sel;

    int n_tests = 0;
    int n_fail  = 0;

    vga_dbuf_fb #(
        .H_RES   (8),
        .V_RES   (4),
        .SCALE   (1),
        .PIX_W   (PIX_W),
        .BG_COLOR(24'h0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .h_addr     (h_addr),
        .v_addr     (v_addr),
        .frame_start(frame_start),
        .vga_data   (vga_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_x       (wr_x),
        .wr_y       (wr_y),
        .wr_data    (wr_data),
        .clear_req  (clear_req),
        .clear_color(clear_color),
        .swap_req   (swap_req),
        .busy       (busy),
        .swap_done  (swap_done),
        .front_sel  (front_sel)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic swap_now();
        swap_req = 1'b1;
        tick();
        swap_req    = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Reads every buffer word through the top-left display pixel of its 2x2 block.
    task automatic read_buf(input string tag, input logic [PIX_W-1:0] exp);
        for (int y = 0; y < 2; y++) begin
            for (int x = 0; x < 4; x++) begin
                h_addr = 10'(2 * x);
                v_addr = 10'(2 * y);
                tick();
                chk(tag, 32'(vga_data), 32'(exp));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        h_addr = '0; v_addr = '0; wr_x = '0; wr_y = '0;
        frame_start = 1'b0; wr_valid = 1'b0; clear_req = 1'b0; swap_req = 1'b0;
        wr_data = '0; clear_color = '0;

        // 1. reset
        tick();
        tick();
        chk("rst_vga_data", 32'(vga_data), 32'h0);
        chk("rst_front_sel", 32'(front_sel), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_swap_done", 32'(swap_done), 32'h0);
        chk("rst_wr_ready", 32'(wr_ready), 32'h0);
        rst = 1'b0;
        #1;
        chk("post_rst_wr_ready", 32'(wr_ready), 32'h1);

        // 2. write then swap at a delayed frame_start
        wr_valid = 1'b1; wr_x = 10'd1; wr_y = 10'd0; wr_data = 24'hFF0000;
        tick();
        wr_valid = 1'b0;
        swap_req = 1'b1;
        frame_start = 1'b1;
        tick();
        swap_req = 1'b0;
        frame_start = 1'b0;
        chk("swap_wait_busy", 32'(busy), 32'h1);
        chk("swap_wait_front", 32'(front_sel), 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("swap_wait_no_done", 32'(swap_done), 32'h0);
        end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("swap_done_pulse", 32'(swap_done), 32'h1);
        chk("swap_front_sel", 32'(front_sel), 32'h1);
        chk("swap_busy_clear", 32'(busy), 32'h0);
        h_addr = 10'd2; v_addr = 10'd0;
        tick();
        chk("swap_done_one_cycle", 32'(swap_done), 32'h0);
        chk("read_2_0", 32'(vga_data), 32'hFF0000);
        h_addr = 10'd3; v_addr = 10'd1;
        tick();
        chk("read_3_1", 32'(vga_data), 32'hFF0000);

        // 3. clear back bank (bank 0) and swap it in
        clear_req = 1'b1; clear_color = 24'h00FF00;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("clear_busy", 32'(busy), 32'h1);
            chk("clear_wr_ready", 32'(wr_ready), 32'h0);
            tick();
        end
        chk("clear_done_busy", 32'(busy), 32'h0);
        chk("clear_done_wr_ready", 32'(wr_ready), 32'h1);
        swap_now();
        chk("clear_swap_front", 32'(front_sel), 32'h0);
        chk("clear_swap_done", 32'(swap_done), 32'h1);
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 8; x++) begin
                h_addr = 10'(x);
                v_addr = 10'(y);
                tick();
                chk("clear_read_all", 32'(vga_data), 32'h00FF00);
            end
        end

        // 4. out-of-range display and producer coordinates
        h_addr = 10'd8; v_addr = 10'd0;
        tick();
        chk("bg_h8", 32'(vga_data), 32'h0);
        h_addr = 10'd0; v_addr = 10'd4;
        tick();
        chk("bg_v4", 32'(vga_data), 32'h0);
        clear_req = 1'b1; clear_color = 24'h0000FF;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        wr_valid = 1'b1; wr_x = 10'd4; wr_y = 10'd0; wr_data = 24'hABCDEF;
        #1;
        chk("oob_x_ready", 32'(wr_ready), 32'h1);
        tick();
        wr_x = 10'd0; wr_y = 10'd2;
        #1;
        chk("oob_y_ready", 32'(wr_ready), 32'h1);
        tick();
        wr_valid = 1'b0;
        swap_now();
        chk("oob_swap_front", 32'(front_sel), 32'h1);
        read_buf("oob_bank1", 24'h0000FF);
        swap_now();
        chk("oob_swap_back_front", 32'(front_sel), 32'h0);
        read_buf("oob_bank0", 24'h00FF00);

        // 5. clear and swap requested together: clear wins, swap dropped
        clear_req = 1'b1; swap_req = 1'b1; clear_color = 24'h112233;
        tick();
        clear_req = 1'b0; swap_req = 1'b0;
        chk("both_busy", 32'(busy), 32'h1);
        for (int i = 0; i < 8; i++) tick();
        chk("both_idle", 32'(busy), 32'h0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("both_front_unchanged", 32'(front_sel), 32'h0);
        chk("both_no_swap_done", 32'(swap_done), 32'h0);

        // 6. reset cancels a pending swap
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        chk("cancel_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("cancel_rst_busy", 32'(busy), 32'h0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("cancel_front", 32'(front_sel), 32'h0);
        chk("cancel_no_done", 32'(swap_done), 32'h0);
        chk("cancel_wr_ready", 32'(wr_ready), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
